fsub_seq: RTL and testbench

Sequential IEEE-754 subtractor computing `out = a - b` with valid/ready handshakes on both sides. Internally it negates `b` and performs a signed-magnitude add. Exponent alignment and add take one cycle each, and leading-zero normalisation shifts one bit per cycle. It is the companion of the combinational `fadd` in the floating-point datapath. It is used where the operation is subtraction and timing closure matters more than latency.

---
 rtl/fsub_seq.sv | 185 ++++++++++++++++++
 tb/tb_fsub_seq.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/fsub_seq.sv
`default_nettype none
// ============================================================================
// Module   : fsub_seq
// Brief    : Multi-cycle IEEE-754 subtractor (out = a - b) with valid/ready on
//            both sides; define FSUB_SPECIAL_EN for NaN/inf handling.
// Revision : 1.0
// ============================================================================
module fsub_seq #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out
);
    localparam int c_EW = (N == 64) ? 11 : 8;
    localparam int c_MW = N - 1 - c_EW;
    localparam logic [c_EW-1:0] c_SHMAX = c_EW'(c_MW + 1);
    localparam logic [c_EW-1:0] c_EONE  = c_EW'(1);
`ifdef FSUB_SPECIAL_EN
    localparam logic [c_EW-1:0] c_EMAX = '1;
    localparam logic [N-1:0]    c_QNAN = {1'b0, {c_EW{1'b1}}, 1'b1, {(c_MW-1){1'b0}}};
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ALIGN = 3'd1,
        S_ADD   = 3'd2,
        S_NORM  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          state_q;
    logic [N-1:0]    opa_q, opb_q;
    logic            s_q, sub_q;
    logic [c_EW-1:0] e_q;
    logic [c_MW:0]   ml_q, ms_q, m_q;
    logic            in_ready_q, out_valid_q;
    logic [N-1:0]    out_q;

    logic [c_EW-1:0] w_ea, w_eb, w_el, w_es, w_diff, w_einc;
    logic [c_MW-1:0] w_fa, w_fb;
    logic [c_MW:0]   w_ma, w_mb, w_ml, w_ms, w_msh, w_dif;
    logic [c_MW+1:0] w_sum;
    logic            w_swap, w_sl, w_ss, w_spec, w_ovf;
    logic [N-1:0]    w_spec_val;

    always_comb begin
        w_ea   = opa_q[N-2:c_MW];
        w_eb   = opb_q[N-2:c_MW];
        w_fa   = opa_q[c_MW-1:0];
        w_fb   = opb_q[c_MW-1:0];
        // Zero exponent flushes the operand (zero or subnormal) to a signed zero.
        w_ma   = (w_ea == '0) ? '0 : {1'b1, w_fa};
        w_mb   = (w_eb == '0) ? '0 : {1'b1, w_fb};
        w_swap = {w_eb, w_mb} > {w_ea, w_ma};
        w_el   = w_swap ? w_eb : w_ea;
        w_es   = w_swap ? w_ea : w_eb;
        w_ml   = w_swap ? w_mb : w_ma;
        w_ms   = w_swap ? w_ma : w_mb;
        w_sl   = w_swap ? opb_q[N-1] : opa_q[N-1];
        w_ss   = w_swap ? opa_q[N-1] : opb_q[N-1];
        w_diff = w_el - w_es;
        w_msh  = (w_diff >= c_SHMAX) ? '0 : (w_ms >> w_diff);
        w_sum  = {1'b0, ml_q} + {1'b0, ms_q};
        w_dif  = ml_q - ms_q;
        w_einc = e_q + c_EONE;
        w_spec     = 1'b0;
        w_spec_val = '0;
`ifdef FSUB_SPECIAL_EN
        if ((w_ea == c_EMAX && w_fa != '0) || (w_eb == c_EMAX && w_fb != '0)) begin
            w_spec     = 1'b1;
            w_spec_val = c_QNAN;
        end else if (w_ea == c_EMAX && w_eb == c_EMAX) begin
            w_spec     = 1'b1;
            w_spec_val = (opa_q[N-1] != opb_q[N-1]) ? c_QNAN
                                                    : {opa_q[N-1], c_EMAX, {c_MW{1'b0}}};
        end else if (w_ea == c_EMAX) begin
            w_spec     = 1'b1;
            w_spec_val = {opa_q[N-1], c_EMAX, {c_MW{1'b0}}};
        end else if (w_eb == c_EMAX) begin
            w_spec     = 1'b1;
            w_spec_val = {opb_q[N-1], c_EMAX, {c_MW{1'b0}}};
        end
        w_ovf = w_sum[c_MW+1] && (w_einc == c_EMAX);
`else
        w_ovf = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            opa_q       <= '0;
            opb_q       <= '0;
            s_q         <= 1'b0;
            sub_q       <= 1'b0;
            e_q         <= '0;
            ml_q        <= '0;
            ms_q        <= '0;
            m_q         <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        opa_q      <= a;
                        opb_q      <= {~b[N-1], b[N-2:0]};
                        in_ready_q <= 1'b0;
                        state_q    <= S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    if (w_spec) begin
                        out_q       <= w_spec_val;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        s_q     <= w_sl;
                        sub_q   <= w_sl ^ w_ss;
                        e_q     <= w_el;
                        ml_q    <= w_ml;
                        ms_q    <= w_msh;
                        state_q <= S_ADD;
                    end
                end
                S_ADD: begin
                    state_q <= S_NORM;
                    if (sub_q) begin
                        m_q <= w_dif;
                    end else if (w_ovf) begin
                        out_q       <= {s_q, {c_EW{1'b1}}, {c_MW{1'b0}}};
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else if (w_sum[c_MW+1]) begin
                        m_q <= w_sum[c_MW+1:1];
                        e_q <= w_einc;
                    end else begin
                        m_q <= w_sum[c_MW:0];
                    end
                end
                S_NORM: begin
                    // A zero sum from like signs can only be (-0)+(-0), so keep its sign.
                    if (m_q == '0) begin
                        out_q       <= {s_q & ~sub_q, {(N-1){1'b0}}};
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else if (m_q[c_MW]) begin
                        out_q       <= {s_q, e_q, m_q[c_MW-1:0]};
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else if (e_q == c_EONE) begin
                        out_q       <= {s_q, {c_EW{1'b0}}, m_q[c_MW-1:0]};
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        m_q <= {m_q[c_MW-1:0], 1'b0};
                        e_q <= e_q - c_EONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out       = out_q;
endmodule
`default_nettype wire

// File: tb/tb_fsub_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_fsub_seq
// Brief    : Directed vector table plus handshake/reset sequences for fsub_seq.
// Revision : 1.0
// ============================================================================
module tb_fsub_seq;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        string       name;
        logic [31:0] va;
        logic [31:0] vb;
        logic [31:0] vexp;
        int          vlat;
    } vec_t;

    vec_t vecs[13];

    fsub_seq #(.N(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out      (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Launch one operation, return its result and the number of edges after accept.
    task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_op,
                         output logic [31:0] res, output int lat);
        int t;
        t = 0;
        while (!in_ready && t < 20) begin
            @(posedge clk); #1; t++;
        end
        a = ta; b = tb_op; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 60) begin
            @(posedge clk); #1; lat++;
        end
        res = out;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] res;
        logic [31:0] held;
        int          lat;
        logic        stable;

        vecs[0]  = '{"3.0-1.0",        32'h40400000, 32'h3F800000, 32'h40000000, 3};
        vecs[1]  = '{"1.0-(-1.0)",     32'h3F800000, 32'hBF800000, 32'h40000000, 3};
        vecs[2]  = '{"1.0-0.75",       32'h3F800000, 32'h3F400000, 32'h3E800000, 5};
        vecs[3]  = '{"1.0-1.0",        32'h3F800000, 32'h3F800000, 32'h00000000, 3};
        vecs[4]  = '{"0-2.5",          32'h00000000, 32'h40200000, 32'hC0200000, 3};
        vecs[5]  = '{"2.5-0",          32'h40200000, 32'h00000000, 32'h40200000, 3};
        vecs[6]  = '{"+0-+0",          32'h00000000, 32'h00000000, 32'h00000000, 3};
        vecs[7]  = '{"-0-+0",          32'h80000000, 32'h00000000, 32'h80000000, 3};
        vecs[8]  = '{"2.0-1.5",        32'h40000000, 32'h3FC00000, 32'h3F000000, 5};
        vecs[9]  = '{"1.5-(-1.5)",     32'h3FC00000, 32'hBFC00000, 32'h40400000, 3};
        vecs[10] = '{"1.0-2^-24",      32'h3F800000, 32'h33800000, 32'h3F800000, 3};
        vecs[11] = '{"denorm_out",     32'h01000000, 32'h00C00000, 32'h00400000, 4};
        vecs[12] = '{"-1.0-0.5",       32'hBF800000, 32'h3F000000, 32'hBFC00000, 3};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out",       out,                32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 13; i++) begin
            do_op(vecs[i].va, vecs[i].vb, res, lat);
            chk({vecs[i].name, " result"},  res, vecs[i].vexp);
            chk({vecs[i].name, " latency"}, lat, vecs[i].vlat);
        end

`ifdef FSUB_SPECIAL_EN
        do_op(32'h7F800000, 32'h7F800000, res, lat);
        chk("inf-inf qnan", res, 32'h7FC00000);
`endif

        // Backpressure: hold out_ready low five cycles once the result appears.
        a = 32'h40400000; b = 32'h3F800000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("busy_in_ready", {31'd0, in_ready}, 32'd0);
        lat = 0;
        while (!out_valid && lat < 60) begin
            @(posedge clk); #1; lat++;
        end
        held = out;
        chk("bp_first_out", held, 32'h40000000);
        stable = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            if (out !== held || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
        end
        chk("bp_stable", {31'd0, stable}, 32'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_valid_drop", {31'd0, out_valid}, 32'd0);
        chk("bp_ready_back", {31'd0, in_ready},  32'd1);

        // Stray out_ready with nothing pending must not produce a result.
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("stray_ready", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset during NORM (1.0-0.75 needs two shift cycles).
        a = 32'h3F800000; b = 32'h3F400000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_out",       out,                32'd0);
        chk("arst_in_ready",  {31'd0, in_ready},  32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("arst_lost", {31'd0, out_valid}, 32'd0);

        do_op(32'h40400000, 32'h3F800000, res, lat);
        chk("post_rst result", res, 32'h40000000);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
`default_nettype wire
